vigna_mdu_arb: RTL and testbench
================================

VIGNA_MDU_ARB -- requirements
Module: vigna_mdu_arb

Interface
REQ-001 SHALL have parameter ID_R0, default 3'd0: value driven on m_id while requester 0 holds the grant.
REQ-002 SHALL have parameter ID_R1, default 3'd1: value driven on m_id while requester 1 holds the grant.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports r0_valid / r1_valid  input  1  operation request, held until the matching rN_ready.
REQ-006 SHALL have ports r0_func / r1_func  input  3  M-extension opcode (000 mul ... 111 remu).
REQ-007 SHALL have ports r0_op1, r0_op2 / r1_op1, r1_op2  input  32  operands.
REQ-008 SHALL have ports r0_ready / r1_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports r0_result / r1_result  output  32  registered result, valid while rN_ready=1 and held until next completion for that requester.
REQ-010 SHALL have ports m_valid  output  1;  m_func  output  3;  m_id  output  3;  m_op1, m_op2  output  32: shared-unit request side, all registered.
REQ-011 SHALL have ports m_ready  input  1  unit completion pulse;  m_result  input  32  unit result, sampled when m_ready=1.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE.
REQ-014 In IDLE with any rN_valid=1, SHALL select a winner and, on the same edge, latch its func/op1/op2 into m_func/m_op1/m_op2, drive m_id=ID_Rn, set m_valid=1, record grant, and go to ISSUE.
REQ-015 In ISSUE, m_valid and all m_* fields SHALL stay constant until m_ready=1.
REQ-016 On the edge where m_ready=1 in ISSUE, SHALL capture m_result into the granted rN_result, clear m_valid, and go to RESP.
REQ-017 In RESP, SHALL assert the granted rN_ready for exactly one cycle, then go to IDLE. The non-granted rN_ready SHALL stay 0.
REQ-018 Minimum latency SHALL be: request sampled at edge E; m_valid high from E; rN_ready high in the cycle after the m_ready cycle.
REQ-019 After RESP, IDLE SHALL re-arbitrate from the current rN_valid levels. The mandatory IDLE cycle gives the requester time to drop valid and lets the unit return to idle.
REQ-020 Deassertion of rN_valid after grant SHALL be ignored: the operation completes and rN_ready still pulses.
REQ-021 m_ready arriving outside ISSUE SHALL be ignored.
REQ-022 No outputs SHALL depend combinationally on any input.

Reset
REQ-023 While resetn=0: state=IDLE; m_valid=0; m_func=0; m_id=0; m_op1=m_op2=0; r0_ready=r1_ready=0; r0_result=r1_result=0; busy=0; last-grant pointer=1, so requester 0 wins the first tie.
REQ-024 Reset asserted mid-operation SHALL abort immediately: no rN_ready pulse and no result update. After release, the block SHALL start in IDLE.

Configuration
REQ-025 Macro VIGNA_MDU_ARB_RR_EN defined: when both rN_valid=1 in IDLE, SHALL grant the requester not recorded as last granted (round-robin).
REQ-026 Macro VIGNA_MDU_ARB_RR_EN undefined: requester 0 SHALL always win ties (fixed priority); the last-grant register is still maintained.

Verification
REQ-027 Single op: r0 mul 7*6 and unit model returns 42 after 34 cycles -> m_func=000, m_id=0, m_op1=7, m_op2=6; r0_ready one pulse with r0_result=42; r1_ready never pulses.
REQ-028 Tie with RR_EN: r0 and r1 held valid for 4 operations -> grants r0,r1,r0,r1. Without RR_EN -> grants r0,r0,r0,r0 while r0 stays valid.
REQ-029 Operand stability: r1 divu 100/7 is granted, then r1_op1 changes to 5 during ISSUE -> m_op1 stays 100; r1_result=14.
REQ-030 Early drop: r0_valid deasserted 2 cycles after grant -> m_valid held until m_ready; r0_ready still pulses with the correct result.
REQ-031 Reset mid-op: resetn low during ISSUE -> m_valid=0 and busy=0 immediately; no rN_ready pulse; first request after release is served normally.
REQ-032 Spurious m_ready while in IDLE -> no state change, and no rN_ready or rN_result change.

Source files
------------

// File: rtl/vigna_mdu_arb.sv
// Two-requester arbiter in front of one shared multiply/divide unit.
// Optional macro VIGNA_MDU_ARB_RR_EN: round-robin tie-break (default: requester 0 wins ties).
module vigna_mdu_arb #(
   parameter logic [2:0] ID_R0 = 3'd0,
   parameter logic [2:0] ID_R1 = 3'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        r0_valid,
   input  logic [2:0]  r0_func,
   input  logic [31:0] r0_op1,
   input  logic [31:0] r0_op2,
   output logic        r0_ready,
   output logic [31:0] r0_result,
   input  logic        r1_valid,
   input  logic [2:0]  r1_func,
   input  logic [31:0] r1_op1,
   input  logic [31:0] r1_op2,
   output logic        r1_ready,
   output logic [31:0] r1_result,
   output logic        m_valid,
   output logic [2:0]  m_func,
   output logic [2:0]  m_id,
   output logic [31:0] m_op1,
   output logic [31:0] m_op2,
   input  logic        m_ready,
   input  logic [31:0] m_result,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state;
   logic   grant;       // requester currently being served
   logic   last_grant;  // requester served most recently
   logic   pick_r1;

   always_comb begin
      pick_r1 = r1_valid & ~r0_valid;
`ifdef VIGNA_MDU_ARB_RR_EN
      if (r0_valid && r1_valid)
         pick_r1 = ~last_grant;
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         m_valid    <= 1'b0;
         m_func     <= '0;
         m_id       <= '0;
         m_op1      <= '0;
         m_op2      <= '0;
         r0_ready   <= 1'b0;
         r1_ready   <= 1'b0;
         r0_result  <= '0;
         r1_result  <= '0;
         busy       <= 1'b0;
      end else begin
         r0_ready <= 1'b0;
         r1_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (r0_valid || r1_valid) begin
                  if (pick_r1) begin
                     m_func <= r1_func;
                     m_op1  <= r1_op1;
                     m_op2  <= r1_op2;
                     m_id   <= ID_R1;
                  end else begin
                     m_func <= r0_func;
                     m_op1  <= r0_op1;
                     m_op2  <= r0_op2;
                     m_id   <= ID_R0;
                  end
                  grant      <= pick_r1;
                  last_grant <= pick_r1;
                  m_valid    <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ready) begin
                  if (grant) begin
                     r1_result <= m_result;
                     r1_ready  <= 1'b1;
                  end else begin
                     r0_result <= m_result;
                     r0_ready  <= 1'b1;
                  end
                  m_valid <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vigna_mdu_arb.sv
// Self-checking bench for vigna_mdu_arb: transaction-level model plus directed scenarios.
// Honors VIGNA_MDU_ARB_RR_EN the same way as the design.
module tb_vigna_mdu_arb;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        r0_valid = 1'b0, r1_valid = 1'b0;
   logic [2:0]  r0_func = '0, r1_func = '0;
   logic [31:0] r0_op1 = '0, r0_op2 = '0, r1_op1 = '0, r1_op2 = '0;
   logic        r0_ready, r1_ready;
   logic [31:0] r0_result, r1_result;
   logic        m_valid;
   logic [2:0]  m_func, m_id;
   logic [31:0] m_op1, m_op2;
   logic        m_ready;
   logic [31:0] m_result;
   logic        busy;

   logic        unit_mr = 1'b0, spur_mr = 1'b0;
   logic [31:0] unit_res = '0;
   int unsigned lat = 4;

   assign m_ready  = unit_mr | spur_mr;
   assign m_result = unit_mr ? unit_res : 32'hDEAD_BEEF;

   vigna_mdu_arb #(.ID_R0(3'd0), .ID_R1(3'd1)) dut (
      .clk(clk), .resetn(resetn),
      .r0_valid(r0_valid), .r0_func(r0_func), .r0_op1(r0_op1), .r0_op2(r0_op2),
      .r0_ready(r0_ready), .r0_result(r0_result),
      .r1_valid(r1_valid), .r1_func(r1_func), .r1_op1(r1_op1), .r1_op2(r1_op2),
      .r1_ready(r1_ready), .r1_result(r1_result),
      .m_valid(m_valid), .m_func(m_func), .m_id(m_id), .m_op1(m_op1), .m_op2(m_op2),
      .m_ready(m_ready), .m_result(m_result), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      case (f)
         3'd0: alu = a * b;
         3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); alu = p[63:32]; end
         3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); alu = p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; alu = p[63:32]; end
         3'd4: alu = (b == 0) ? '1 : $signed(a) / $signed(b);
         3'd5: alu = (b == 0) ? '1 : a / b;
         3'd6: alu = (b == 0) ? a : $signed(a) % $signed(b);
         default: alu = (b == 0) ? a : a % b;
      endcase
   endfunction

   // Emulated shared unit: answers lat cycles after seeing a request.
   initial begin
      int unsigned cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin unit_mr = 1'b0; cnt = 0; end
         else if (unit_mr) begin unit_mr = 1'b0; cnt = 0; end
         else if (m_valid) begin
            cnt++;
            if (cnt >= lat) begin
               unit_mr  = 1'b1;
               unit_res = alu(m_func, m_op1, m_op2);
            end
         end else cnt = 0;
      end
   end

   // Pulse counters and grant log.
   int rdy0_cnt = 0, rdy1_cnt = 0;
   int grants[$];
   logic mv_prev = 1'b0;
   initial forever begin
      @(negedge clk);
      if (r0_ready) rdy0_cnt++;
      if (r1_ready) rdy1_cnt++;
      if (m_valid && !mv_prev) grants.push_back(int'(m_id));
      mv_prev = m_valid;
   end

   // Transaction model: one operation in flight; result returned in the cycle after the unit answers.
   logic        e_busy = 0, e_mv = 0, e_rdy0 = 0, e_rdy1 = 0, e_who = 0, e_last = 1;
   logic [2:0]  e_func = '0, e_id = '0;
   logic [31:0] e_op1 = '0, e_op2 = '0, e_res0 = '0, e_res1 = '0;

   initial begin
      logic s_v0, s_v1, s_mr, who;
      logic [2:0] s_f0, s_f1;
      logic [31:0] s_a0, s_b0, s_a1, s_b1, res;
      forever begin
         @(posedge clk);
         s_v0 = r0_valid; s_v1 = r1_valid; s_mr = m_ready;
         s_f0 = r0_func; s_a0 = r0_op1; s_b0 = r0_op2;
         s_f1 = r1_func; s_a1 = r1_op1; s_b1 = r1_op2;
         if (!resetn) begin
            e_busy = 0; e_mv = 0; e_rdy0 = 0; e_rdy1 = 0; e_last = 1;
            e_res0 = '0; e_res1 = '0;
         end else if (e_rdy0 || e_rdy1) begin
            e_rdy0 = 0; e_rdy1 = 0; e_busy = 0;
         end else if (e_mv) begin
            if (s_mr) begin
               res = alu(e_func, e_op1, e_op2);
               if (e_who) begin e_res1 = res; e_rdy1 = 1; end
               else begin e_res0 = res; e_rdy0 = 1; end
               e_mv = 0;
            end
         end else if (s_v0 || s_v1) begin
            if (s_v0 && s_v1) begin
`ifdef VIGNA_MDU_ARB_RR_EN
               who = ~e_last;
`else
               who = 1'b0;
`endif
            end else who = s_v1;
            e_who = who; e_last = who;
            e_func = who ? s_f1 : s_f0;
            e_op1  = who ? s_a1 : s_a0;
            e_op2  = who ? s_b1 : s_b0;
            e_id   = who ? 3'd1 : 3'd0;
            e_mv = 1; e_busy = 1;
         end
         #1;
         chk("m_valid", m_valid, e_mv);
         chk("busy", busy, e_busy);
         chk("r0_ready", r0_ready, e_rdy0);
         chk("r1_ready", r1_ready, e_rdy1);
         chk("r0_result", r0_result, e_res0);
         chk("r1_result", r1_result, e_res1);
         if (e_mv) begin
            chk("m_func", m_func, e_func);
            chk("m_id", m_id, e_id);
            chk("m_op1", m_op1, e_op1);
            chk("m_op2", m_op2, e_op2);
         end
      end
   end

   task automatic wait_mvalid();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_valid) begin ok = 1; break; end
      end
      chk("timeout_m_valid", ok, 1'b1);
   endtask

   task automatic wait_ready(input int n);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((n == 0) ? r0_ready : r1_ready) begin ok = 1; break; end
      end
      chk("timeout_ready", ok, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk); resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int exp_g[4];
      int base0, base1;
      bit done;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_m_valid", m_valid, 1'b0);  chk("rst_busy", busy, 1'b0);
      chk("rst_m_func", m_func, 3'd0);    chk("rst_m_id", m_id, 3'd0);
      chk("rst_m_op1", m_op1, 32'd0);     chk("rst_m_op2", m_op2, 32'd0);
      chk("rst_r0_ready", r0_ready, 1'b0); chk("rst_r1_ready", r1_ready, 1'b0);
      chk("rst_r0_result", r0_result, 32'd0); chk("rst_r1_result", r1_result, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Single op: 7*6 with a 34-cycle unit
      lat = 34; base0 = rdy0_cnt; base1 = rdy1_cnt;
      r0_func = 3'd0; r0_op1 = 32'd7; r0_op2 = 32'd6; r0_valid = 1'b1;
      wait_mvalid();
      chk("t1_m_func", m_func, 3'd0); chk("t1_m_id", m_id, 3'd0);
      chk("t1_m_op1", m_op1, 32'd7);  chk("t1_m_op2", m_op2, 32'd6);
      wait_ready(0);
      chk("t1_r0_result", r0_result, 32'd42);
      r0_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t1_r0_pulses", rdy0_cnt - base0, 32'd1);
      chk("t1_r1_pulses", rdy1_cnt - base1, 32'd0);

      // Tie: both held valid for 4 operations
      do_reset();
      lat = 3; grants.delete();
      r0_func = 3'd0; r0_op1 = 32'd2; r0_op2 = 32'd3;
      r1_func = 3'd0; r1_op1 = 32'd4; r1_op2 = 32'd5;
      r0_valid = 1'b1; r1_valid = 1'b1;
      done = 0;
      begin
         int n = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (r0_ready || r1_ready) n++;
            if (n == 4) begin done = 1; break; end
         end
      end
      chk("t2_timeout", done, 1'b1);
      r0_valid = 1'b0; r1_valid = 1'b0;
      repeat (3) @(negedge clk);
`ifdef VIGNA_MDU_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      chk("t2_grant_count", grants.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < grants.size()) chk($sformatf("t2_grant%0d", i), grants[i], exp_g[i]);

      // Operand stability: r1 divu 100/7, op1 changed during ISSUE
      lat = 6;
      r1_func = 3'd5; r1_op1 = 32'd100; r1_op2 = 32'd7; r1_valid = 1'b1;
      wait_mvalid();
      @(negedge clk); r1_op1 = 32'd5;
      @(negedge clk);
      chk("t3_m_op1_held", m_op1, 32'd100);
      wait_ready(1);
      chk("t3_r1_result", r1_result, 32'd14);
      r1_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Early drop: r0 remu 100%7, valid dropped 2 cycles after grant
      lat = 8; base0 = rdy0_cnt;
      r0_func = 3'd7; r0_op1 = 32'd100; r0_op2 = 32'd7; r0_valid = 1'b1;
      wait_mvalid();
      @(negedge clk); @(negedge clk);
      r0_valid = 1'b0;
      @(negedge clk);
      chk("t4_m_valid_held", m_valid, 1'b1);
      wait_ready(0);
      chk("t4_r0_result", r0_result, 32'd2);
      repeat (2) @(negedge clk);
      chk("t4_r0_pulses", rdy0_cnt - base0, 32'd1);

      // Spurious m_ready in IDLE
      base0 = rdy0_cnt; base1 = rdy1_cnt;
      spur_mr = 1'b1;
      @(negedge clk); spur_mr = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_busy", busy, 1'b0);
      chk("t5_m_valid", m_valid, 1'b0);
      chk("t5_r0_result", r0_result, 32'd2);
      chk("t5_r1_result", r1_result, 32'd14);
      chk("t5_pulses", (rdy0_cnt - base0) + (rdy1_cnt - base1), 32'd0);

      // Reset mid-op, then a normal request
      lat = 20; base0 = rdy0_cnt; base1 = rdy1_cnt;
      r0_func = 3'd0; r0_op1 = 32'd9; r0_op2 = 32'd9; r0_valid = 1'b1;
      wait_mvalid();
      repeat (3) @(negedge clk);
      resetn = 1'b0; r0_valid = 1'b0;
      #1;
      chk("t6_m_valid", m_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_r0_result", r0_result, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_pulses", (rdy0_cnt - base0) + (rdy1_cnt - base1), 32'd0);
      lat = 2;
      r1_func = 3'd0; r1_op1 = 32'd3; r1_op2 = 32'd5; r1_valid = 1'b1;
      wait_ready(1);
      chk("t6_r1_result", r1_result, 32'd15);
      r1_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
